// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the core memory port arbiter
package mem_arb_pkg;
  typedef enum logic {SRC_INSTR, SRC_DATA} mem_src_e;
  typedef struct packed {
    mem_src_e src;
    logic     discard;
  } mem_tag_t;
  localparam logic [3:0] INSTR_BE = 4'hF;
endpackage

// File: rtl/mem_tag_fifo.sv
// mem_tag_fifo: in-order tag FIFO for outstanding transactions, with a
// broadcast that marks every queued instruction entry as discarded.
module mem_tag_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rstn,
  input  logic     push,
  input  mem_tag_t push_tag,
  input  logic     pop,
  input  logic     set_discard,
  output mem_tag_t head,
  output logic     full,
  output logic     empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  mem_tag_t       mem [DEPTH];
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  count;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (set_discard && mem[i].src == SRC_INSTR) mem[i].discard <= 1'b1;
      // the pushed entry carries its own discard and overrides the broadcast
      if (push) begin
        mem[wr_ptr] <= push_tag;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign head  = mem[rd_ptr];
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and LSU, with
// starvation guard, in-order response routing and fetch-flush discard.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        instr_flush_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        proto_err_o
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;
  logic          full, empty, instr_sel, data_sel, hs, pop, head_instr, head_drop;
  mem_tag_t      head;
  assign instr_sel   = instr_req_i & (~data_req_i | starve_cnt == SW'(STARVE_LIMIT));
  assign data_sel    = data_req_i & ~instr_sel;
  assign mem_req_o   = (instr_req_i | data_req_i) & ~full;
  assign hs          = mem_req_o & mem_gnt_i;
  assign instr_gnt_o = hs & instr_sel;
  assign data_gnt_o  = hs & data_sel;
  assign mem_we_o    = data_sel & data_we_i;
  assign mem_be_o    = instr_sel ? INSTR_BE : data_sel ? data_be_i : '0;
  assign mem_addr_o  = instr_sel ? instr_addr_i : data_sel ? data_addr_i : '0;
  assign mem_wdata_o = data_sel ? data_wdata_i : '0;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) starve_cnt <= '0;
    else if (!instr_req_i || instr_gnt_o) starve_cnt <= '0;
    else if (data_gnt_o && starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) proto_err_o <= 1'b0;
    else if (mem_rvalid_i && empty) proto_err_o <= 1'b1;
  end
  mem_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push       (hs),
    .push_tag   ('{src: instr_sel ? SRC_INSTR : SRC_DATA, discard: instr_sel & instr_flush_i}),
    .pop        (pop),
    .set_discard(instr_flush_i),
    .head       (head),
    .full       (full),
    .empty      (empty)
  );
  // a flush in the pop cycle also suppresses that response
  assign pop            = mem_rvalid_i & ~empty;
  assign head_instr     = head.src == SRC_INSTR;
  assign head_drop      = head.discard | instr_flush_i;
  assign instr_rvalid_o = pop & head_instr & ~head_drop;
  assign instr_err_o    = instr_rvalid_o & mem_err_i;
  assign data_rvalid_o  = pop & ~head_instr;
  assign data_err_o     = data_rvalid_o & mem_err_i;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven directed test of the memory port arbiter
// plus hand-written starvation and reset sequences.
module tb_mem_port_arbiter;
  logic        clk = 1'b0, rstn = 1'b0;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o, instr_flush_i;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
  logic [3:0]  data_be_i, mem_be_o;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, mem_err_i, proto_err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rstn(rstn),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .instr_flush_i(instr_flush_i),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i), .proto_err_o(proto_err_o)
  );

  typedef struct packed {
    logic ir; logic [31:0] ia; logic fl; logic dr; logic dwe; logic [3:0] dbe;
    logic [31:0] da; logic [31:0] dwd; logic gnt; logic rv; logic [31:0] rd; logic er;
  } in_t;
  typedef struct packed {
    logic mreq; logic ig; logic dg; logic irv; logic drv; logic ie; logic de; logic pe;
    logic [31:0] maddr; logic [3:0] mbe; logic mwe; logic [31:0] mwd;
  } exp_t;
  typedef struct packed { in_t i; exp_t e; } vec_t;
  typedef logic [140:0] obs_t;

  function automatic in_t mi(logic [31:0] ir, logic [31:0] ia, logic [31:0] fl, logic [31:0] dr,
                             logic [31:0] dwe, logic [31:0] dbe, logic [31:0] da, logic [31:0] dwd,
                             logic [31:0] gnt, logic [31:0] rv, logic [31:0] rd, logic [31:0] er);
    return '{ir[0], ia, fl[0], dr[0], dwe[0], dbe[3:0], da, dwd, gnt[0], rv[0], rd, er[0]};
  endfunction
  function automatic exp_t me(logic [31:0] mreq, logic [31:0] ig, logic [31:0] dg, logic [31:0] irv,
                              logic [31:0] drv, logic [31:0] ie, logic [31:0] de, logic [31:0] pe,
                              logic [31:0] maddr, logic [31:0] mbe, logic [31:0] mwe, logic [31:0] mwd);
    return '{mreq[0], ig[0], dg[0], irv[0], drv[0], ie[0], de[0], pe[0], maddr, mbe[3:0], mwe[0], mwd};
  endfunction

  task automatic apply(input in_t v);
    instr_req_i = v.ir; instr_addr_i = v.ia; instr_flush_i = v.fl;
    data_req_i = v.dr; data_we_i = v.dwe; data_be_i = v.dbe; data_addr_i = v.da; data_wdata_i = v.dwd;
    mem_gnt_i = v.gnt; mem_rvalid_i = v.rv; mem_rdata_i = v.rd; mem_err_i = v.er;
  endtask

  function automatic obs_t observed();
    return {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, instr_err_o,
            data_err_o, proto_err_o, mem_addr_o, mem_be_o, mem_we_o, mem_wdata_o,
            instr_rdata_o, data_rdata_o};
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%b exp=%b", name, act, exp);
    end
  endtask

  vec_t vec [24];
  in_t  idle;
  bit   q [$];

  initial begin
    idle = mi(0,0,0,0,0,0,0,0,0,0,0,0);
    vec[0]  = '{idle,                                       me(0,0,0,0,0,0,0,0,0,0,0,0)};
    vec[1]  = '{mi(1,'h100,0,0,0,0,0,0,1,0,0,0),               me(1,1,0,0,0,0,0,0,'h100,'hF,0,0)};
    vec[2]  = '{mi(0,0,0,0,0,0,0,0,0,1,'h13,0),                me(0,0,0,1,0,0,0,0,0,0,0,0)};
    vec[3]  = '{mi(0,0,0,1,1,'h3,'h200,'hDEADBEEF,1,0,0,0),    me(1,0,1,0,0,0,0,0,'h200,'h3,1,'hDEADBEEF)};
    vec[4]  = '{mi(0,0,0,0,0,0,0,0,0,1,0,1),                   me(0,0,0,0,1,0,1,0,0,0,0,0)};
    vec[5]  = '{mi(1,'h104,0,0,0,0,0,0,1,0,0,0),               me(1,1,0,0,0,0,0,0,'h104,'hF,0,0)};
    vec[6]  = '{mi(1,'h108,0,0,0,0,0,0,1,0,0,0),               me(1,1,0,0,0,0,0,0,'h108,'hF,0,0)};
    vec[7]  = '{mi(0,0,0,1,0,'hF,'h300,0,1,0,0,0),             me(0,0,0,0,0,0,0,0,'h300,'hF,0,0)};
    vec[8]  = '{mi(0,0,0,1,0,'hF,'h300,0,1,1,'hA,0),           me(0,0,0,1,0,0,0,0,'h300,'hF,0,0)};
    vec[9]  = '{mi(0,0,0,1,0,'hF,'h300,0,1,0,0,0),             me(1,0,1,0,0,0,0,0,'h300,'hF,0,0)};
    vec[10] = '{mi(0,0,0,0,0,0,0,0,0,1,'hB,0),                 me(0,0,0,1,0,0,0,0,0,0,0,0)};
    vec[11] = '{mi(0,0,0,0,0,0,0,0,0,1,'hC,0),                 me(0,0,0,0,1,0,0,0,0,0,0,0)};
    vec[12] = '{mi(1,'h10C,0,0,0,0,0,0,1,0,0,0),               me(1,1,0,0,0,0,0,0,'h10C,'hF,0,0)};
    vec[13] = '{mi(1,'h110,0,0,0,0,0,0,1,0,0,0),               me(1,1,0,0,0,0,0,0,'h110,'hF,0,0)};
    vec[14] = '{mi(0,0,1,0,0,0,0,0,0,0,0,0),                   me(0,0,0,0,0,0,0,0,0,0,0,0)};
    vec[15] = '{mi(0,0,0,1,0,'hF,'h400,0,1,1,'hD,0),           me(0,0,0,0,0,0,0,0,'h400,'hF,0,0)};
    vec[16] = '{mi(0,0,0,1,0,'hF,'h400,0,1,1,'hE,0),           me(1,0,1,0,0,0,0,0,'h400,'hF,0,0)};
    vec[17] = '{mi(0,0,0,0,0,0,0,0,0,1,'hF,0),                 me(0,0,0,0,1,0,0,0,0,0,0,0)};
    vec[18] = '{mi(1,'h114,0,0,0,0,0,0,1,0,0,0),               me(1,1,0,0,0,0,0,0,'h114,'hF,0,0)};
    vec[19] = '{mi(1,'h118,1,0,0,0,0,0,1,1,'h11,0),            me(1,1,0,0,0,0,0,0,'h118,'hF,0,0)};
    vec[20] = '{mi(0,0,0,0,0,0,0,0,0,1,'h12,0),                me(0,0,0,0,0,0,0,0,0,0,0,0)};
    vec[21] = '{mi(0,0,0,0,0,0,0,0,0,1,'h99,0),                me(0,0,0,0,0,0,0,0,0,0,0,0)};
    vec[22] = '{idle,                                       me(0,0,0,0,0,0,0,1,0,0,0,0)};
    vec[23] = '{idle,                                       me(0,0,0,0,0,0,0,1,0,0,0,0)};

    apply(idle);
    #12 check("reset_state", observed(), '0);
    @(posedge clk); #1 rstn = 1'b1;

    for (int n = 0; n < 24; n++) begin
      apply(vec[n].i);
      #3 check($sformatf("row%0d", n), observed(), {vec[n].e, vec[n].i.rd, vec[n].i.rd});
      @(posedge clk); #1;
    end

    apply(idle);
    rstn = 1'b0;
    #1 check2("proto_err_cleared_by_reset", {1'b0, proto_err_o}, 2'b00);
    @(posedge clk); #1 rstn = 1'b1;

    // both requesters saturate the port: four data grants, then one fetch
    for (int k = 0; k < 15; k++) begin
      bit ig, s;
      ig = (k % 5) == 4;
      apply(mi(1, 'h200 + 4 * k, 0, 1, 0, 'hF, 'h800, 0, 1, k > 0, k, 0));
      #3 check2($sformatf("starve_gnt%0d", k), {instr_gnt_o, data_gnt_o}, {ig, ~ig});
      if (k > 0) begin
        s = q.pop_front();
        check2($sformatf("starve_rsp%0d", k), {instr_rvalid_o, data_rvalid_o}, {s, ~s});
      end
      q.push_back(ig);
      @(posedge clk); #1;
    end
    apply(mi(0,0,0,0,0,0,0,0,0,1,'h55,0));
    #3 check2("starve_drain", {instr_rvalid_o, data_rvalid_o}, {q[0], ~q[0]});
    @(posedge clk); #1 apply(idle);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
